// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC flit width, FIFO depth default, port indices and grant helper
package noc_pkg;
    localparam int FLIT_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int NUM_PORTS = 5;
    typedef enum logic [2:0] {PORT_N, PORT_E, PORT_W, PORT_S, PORT_L} port_e;
    typedef logic [FLIT_WIDTH-1:0] flit_t;
    // true when more than one bit of the grant vector is set
    function automatic logic multi_grant(input logic [NUM_PORTS-1:0] g);
        return (g & (g - NUM_PORTS'(1))) != '0;
    endfunction
endpackage

// File: rtl/noc_input_fifo_if.sv
// noc_input_fifo_if: RTS/DCTS receive link plus head-flit/grant side of one router input channel
interface noc_input_fifo_if
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH
);
    logic [DATA_WIDTH-1:0] rx;
    logic drts;
    logic cts;
    logic grant_n;
    logic grant_e;
    logic grant_w;
    logic grant_s;
    logic grant_l;
    logic [DATA_WIDTH-1:0] data_out;
    logic empty;
    logic full;
    logic grant_err;
    modport master (
        output rx, drts, grant_n, grant_e, grant_w, grant_s, grant_l,
        input cts, data_out, empty, full, grant_err
    );
    modport slave (
        input rx, drts, grant_n, grant_e, grant_w, grant_s, grant_l,
        output cts, data_out, empty, full, grant_err
    );
endinterface

// File: rtl/noc_fifo_mem.sv
// noc_fifo_mem: DEPTH x DATA_WIDTH register file, one write port, one asynchronous read port
module noc_fifo_mem
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/noc_input_fifo.sv
// noc_input_fifo: accepts RTS flits with a one-cycle CTS per flit and buffers them FWFT for the output arbiters
module noc_input_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input logic clk,
    input logic rst,
    noc_input_fifo_if.slave link
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0] count_q, count_d;
    logic cts_q, grant_err_q;
    logic [NUM_PORTS-1:0] grants;
    logic write_en, pop, empty, full;
    assign grants[PORT_N] = link.grant_n;
    assign grants[PORT_E] = link.grant_e;
    assign grants[PORT_W] = link.grant_w;
    assign grants[PORT_S] = link.grant_s;
    assign grants[PORT_L] = link.grant_l;
    assign empty = count_q == '0;
    assign full = count_q == FULL_CNT;
    // registered cts gates the write so a held RTS is only taken once per handshake
    assign write_en = link.drts & ~cts_q & ~full;
    assign pop = (|grants) & ~empty;
    always_comb begin
        wr_ptr_d = write_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d = count_q + (AW+1)'(write_en) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
            cts_q <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
            cts_q <= write_en;
            grant_err_q <= multi_grant(grants);
        end
    end
    noc_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk(clk),
        .we_i(write_en),
        .waddr_i(wr_ptr_q),
        .wdata_i(link.rx),
        .raddr_i(rd_ptr_q),
        .rdata_o(link.data_out)
    );
    assign link.cts = cts_q;
    assign link.empty = empty;
    assign link.full = full;
    assign link.grant_err = grant_err_q;
endmodule

// File: tb/tb_noc_input_fifo.sv
// tb_noc_input_fifo: queue-based reference model checked every cycle plus directed literal checks
module tb_noc_input_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];
    logic m_cts = 1'b0;
    logic m_err = 1'b0;
    bit m_ok = 1'b0;
    noc_input_fifo_if #(.DATA_WIDTH(32)) bus ();
    noc_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .link(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // model: a flit is accepted when RTS is up, no CTS is outstanding and fewer than 4 are held
    always @(posedge clk) begin
        bit acc, pp;
        int ng;
        if (rst) begin
            q.delete();
            m_cts <= 1'b0;
            m_err <= 1'b0;
            m_ok <= 1'b1;
        end else begin
            ng = int'(bus.grant_n) + int'(bus.grant_e) + int'(bus.grant_w) + int'(bus.grant_s) + int'(bus.grant_l);
            acc = bus.drts && !m_cts && q.size() < 4;
            pp = ng > 0 && q.size() > 0;
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(bus.rx);
            m_cts <= acc;
            m_err <= ng > 1;
        end
    end
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
            chk("m_full", 32'(bus.full), 32'(q.size() == 4));
            chk("m_cts", 32'(bus.cts), 32'(m_cts));
            chk("m_grant_err", 32'(bus.grant_err), 32'(m_err));
            if (q.size() > 0) chk("m_data_out", bus.data_out, q[0]);
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [31:0] v);
        bit got = 1'b0;
        bus.drts = 1'b1;
        bus.rx = v;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = bus.cts;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL send_timeout: got no cts expected cts for %h", v);
        end
        bus.drts = 1'b0;
        step();
    endtask
    task automatic pop_with(input int port);
        bus.grant_n = port == 0;
        bus.grant_e = port == 1;
        bus.grant_w = port == 2;
        bus.grant_s = port == 3;
        bus.grant_l = port == 4;
        step();
        {bus.grant_n, bus.grant_e, bus.grant_w, bus.grant_s, bus.grant_l} = '0;
    endtask
    initial begin
        bus.rx = '0;
        bus.drts = 1'b0;
        {bus.grant_n, bus.grant_e, bus.grant_w, bus.grant_s, bus.grant_l} = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_full", 32'(bus.full), 32'd0);
        chk("reset_cts", 32'(bus.cts), 32'd0);
        chk("reset_grant_err", 32'(bus.grant_err), 32'd0);
        bus.drts = 1'b1;
        bus.rx = 32'hA5A5_0001;
        step();
        chk("hs_cts", 32'(bus.cts), 32'd1);
        chk("hs_empty", 32'(bus.empty), 32'd0);
        chk("hs_data", bus.data_out, 32'hA5A5_0001);
        step();
        bus.drts = 1'b0;
        chk("hs_cts_once", 32'(bus.cts), 32'd0);
        step();
        chk("hs_single_write", 32'(bus.full), 32'd0);
        pop_with(0);
        chk("hs_popped_empty", 32'(bus.empty), 32'd1);
        for (int i = 1; i <= 4; i++) send(32'(i));
        chk("fill_full", 32'(bus.full), 32'd1);
        bus.drts = 1'b1;
        bus.rx = 32'h5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fill_blocked_cts", 32'(bus.cts), 32'd0);
        end
        pop_with(1);
        chk("fill_pop_cts", 32'(bus.cts), 32'd0);
        chk("fill_head2", bus.data_out, 32'h2);
        step();
        bus.drts = 1'b0;
        chk("fill_late_cts", 32'(bus.cts), 32'd1);
        chk("fill_full_again", 32'(bus.full), 32'd1);
        step();
        for (int i = 2; i <= 5; i++) begin
            chk("fill_drain", bus.data_out, 32'(i));
            pop_with(2);
        end
        chk("fill_drained", 32'(bus.empty), 32'd1);
        for (int i = 0; i < 10; i++) begin
            send(32'h10 + 32'(i));
            chk("wrap_head", bus.data_out, 32'h10 + 32'(i));
            pop_with(4);
            chk("wrap_empty", 32'(bus.empty), 32'd1);
        end
        send(32'hA0);
        send(32'hA1);
        bus.drts = 1'b1;
        bus.rx = 32'hA2;
        bus.grant_s = 1'b1;
        step();
        bus.drts = 1'b0;
        bus.grant_s = 1'b0;
        chk("sim_cts", 32'(bus.cts), 32'd1);
        chk("sim_head", bus.data_out, 32'hA1);
        step();
        pop_with(3);
        chk("sim_next", bus.data_out, 32'hA2);
        pop_with(3);
        chk("sim_empty", 32'(bus.empty), 32'd1);
        send(32'hD0);
        send(32'hD1);
        send(32'hD2);
        bus.grant_n = 1'b1;
        bus.grant_s = 1'b1;
        step();
        bus.grant_n = 1'b0;
        bus.grant_s = 1'b0;
        chk("gerr_pulse", 32'(bus.grant_err), 32'd1);
        chk("gerr_head", bus.data_out, 32'hD1);
        step();
        chk("gerr_clear", 32'(bus.grant_err), 32'd0);
        pop_with(0);
        pop_with(0);
        chk("gerr_drained", 32'(bus.empty), 32'd1);
        pop_with(4);
        chk("idle_grant_empty", 32'(bus.empty), 32'd1);
        chk("idle_grant_err", 32'(bus.grant_err), 32'd0);
        send(32'hE0);
        send(32'hE1);
        send(32'hE2);
        bus.drts = 1'b1;
        bus.rx = 32'hE3;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.drts = 1'b0;
        chk("rst_mid_empty", 32'(bus.empty), 32'd1);
        chk("rst_mid_cts", 32'(bus.cts), 32'd0);
        step();
        chk("rst_mid_still_empty", 32'(bus.empty), 32'd1);
        send(32'hF0);
        chk("rst_mid_fresh_head", bus.data_out, 32'hF0);
        pop_with(1);
        chk("rst_mid_final_empty", 32'(bus.empty), 32'd1);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
